// File: rtl/rr_resp_demux_lock.sv
// Routes responses back to the requester recorded at arbitration time.
// In-order index FIFO; head selects the output lane; lock_i holds the head.
//
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   flush_i              sync clear of all outstanding entries
//   req_idx_i            arbitrated requester index
//   req_valid_i          arbiter handshake occurred this cycle
//   req_ready_o          an index can be recorded
//   rsp_valid_i          upstream response valid
//   rsp_ready_o          upstream response ready
//   rsp_data_i           upstream response payload
//   lock_i               keep head after the response
//   rsp_valid_o          per-requester valid
//   rsp_ready_i          per-requester ready
//   rsp_data_o           payload broadcast to every lane
//   idx_o                head index (0 when empty)
//   empty_o, count_o     occupancy
module rr_resp_demux_lock #(
  parameter int unsigned NumOut    = 4,
  parameter int unsigned DataWidth = 32,
  parameter type         DataType  = logic [DataWidth-1:0],
  parameter int unsigned Depth     = 4,
  localparam int unsigned IdxWidth = $clog2(NumOut),
  localparam type         idx_t    = logic [IdxWidth-1:0],
  localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic [IdxWidth-1:0]     req_idx_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    rsp_valid_i,
  output logic                    rsp_ready_o,
  input  DataType                 rsp_data_i,
  input  logic                    lock_i,
  output logic [NumOut-1:0]       rsp_valid_o,
  input  logic [NumOut-1:0]       rsp_ready_i,
  output DataType [NumOut-1:0]    rsp_data_o,
  output logic [IdxWidth-1:0]     idx_o,
  output logic                    empty_o,
  output logic [CntWidth-1:0]     count_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

  typedef logic [PtrWidth-1:0] ptr_t;

  idx_t                mem [Depth];
  ptr_t                rd_ptr;
  ptr_t                wr_ptr;
  logic [CntWidth-1:0] cnt;

  idx_t head;
  logic empty;
  logic head_ok;
  logic push;
  logic pop;

  function automatic ptr_t ptr_inc(input ptr_t p);
    if (32'(p) == Depth - 1) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign head    = mem[rd_ptr];
  assign empty   = (cnt == '0);
  assign head_ok = (32'(head) < NumOut);

  assign empty_o     = empty;
  assign count_o     = cnt;
  assign idx_o       = empty ? '0 : head;
  assign req_ready_o = (32'(cnt) < Depth);

  // Out-of-range head still takes the response so upstream never deadlocks.
  always_comb begin
    rsp_valid_o = '0;
    rsp_ready_o = 1'b0;
    if (!empty) begin
      if (head_ok) begin
        rsp_valid_o[head] = rsp_valid_i;
        rsp_ready_o       = rsp_ready_i[head];
      end else begin
        rsp_ready_o = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NumOut; i++) begin : g_lane
    assign rsp_data_o[i] = rsp_data_i;
  end

  assign push = req_valid_i && req_ready_o;
  assign pop  = rsp_valid_i && rsp_ready_o && !lock_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        cnt <= cnt + 1'b1;
      end else if (pop && !push) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Contents need no reset: only entries between the pointers are read.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      mem[wr_ptr] <= req_idx_i;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i) begin
      assert (!(req_valid_i && !req_ready_o))
        else $warning("index push dropped, buffer full");
      assert (!(!empty && !head_ok && rsp_valid_i))
        else $error("response for out-of-range index dropped");
    end
  end
`endif

endmodule
